// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants and types for the 7-segment display source
//               selector: mode codes, default digit width and the cause code
//               for selection-register writes.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Mode code driven while the display is blanked
  localparam logic [3:0] MODE_BLANK = 4'h0;
  // Default indicator codes for the common sources
  localparam logic [3:0] MODE_HHMM  = 4'hf;
  localparam logic [3:0] MODE_SS    = 4'h3;

  // Default width of one BCD/hex digit
  localparam int DEFAULT_DIGIT_W = 4;

  // Which term, if any, writes the selection register this cycle.
  // Listed in priority order (reset is handled directly by the register).
  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_LOAD = 3'd1,
    SEL_NEXT = 3'd2,
    SEL_AUTO = 3'd3,
    SEL_FIX  = 3'd4
  } sel_cause_e;

endpackage
`default_nettype wire

// File: rtl/next_src_finder.sv
`default_nettype none
// ============================================================================
// Module      : next_src_finder
// Description : Combinational cyclic priority search. Returns the first
//               enabled source strictly after sel (wrapping NUM_SRC-1 -> 0),
//               or sel itself when no other source is enabled. none flags
//               that no source at all is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module next_src_finder #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [NUM_SRC-1:0] src_en,
  output logic [SEL_W-1:0]   nxt,
  output logic               none
);

  // Walk sel+1, sel+2, ... modulo NUM_SRC and keep the first enabled hit
  always_comb begin
    int                 w_idx;
    logic               w_found;
    logic [NUM_SRC-1:0] w_rot;
    nxt     = sel;
    w_found = 1'b0;
    w_idx   = 0;
    w_rot   = '0;
    for (int k = 1; k < NUM_SRC; k++) begin
      w_idx = (int'(sel) + k) % NUM_SRC;
      w_rot = src_en >> w_idx;
      if (!w_found && w_rot[0]) begin
        nxt     = SEL_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  assign none = ~|src_en;

endmodule
`default_nettype wire

// File: rtl/display_source_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_source_mux
// Description : Clocked display-source selector for the 7-segment front end.
//               Holds the selection register (advance pulse, direct load,
//               timed auto-rotation, skip of disabled sources), the dwell
//               counter and the registered digit/mode output.
// Revision    : 1.0 - initial release
// ============================================================================
module display_source_mux
  import display_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = DEFAULT_DIGIT_W,
  parameter int DWELL_TICKS = 5,
  parameter int SEL_W       = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_SRC*NUM_DIGITS*DIGIT_W-1:0] src_digits,
  input  logic [NUM_SRC*4-1:0]              src_mode,
  input  logic [NUM_SRC-1:0]                src_en,
  input  logic                              next_pulse,
  input  logic                              sel_load,
  input  logic [SEL_W-1:0]                  sel_value,
  input  logic                              auto_en,
  input  logic                              tick,
  output logic [NUM_DIGITS*DIGIT_W-1:0]     digits,
  output logic [3:0]                        mode_code,
  output logic [SEL_W-1:0]                  sel,
  output logic                              blank
);

  localparam int c_bus_w   = NUM_DIGITS * DIGIT_W;
  // A dwell of one tick still needs a 1-bit counter to stay legal
  localparam int c_dwell_w = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL_TICKS - 1);

  logic [SEL_W-1:0]     r_sel;
  logic [c_dwell_w-1:0] r_dwell;
  logic [c_bus_w-1:0]   r_digits;
  logic [3:0]           r_mode;
  logic                 r_blank;

  logic [SEL_W-1:0]     w_nxt;
  logic                 w_none;
  logic                 w_load_ok;
  logic                 w_auto_adv;
  logic                 w_sel_write;
  logic [SEL_W-1:0]     w_sel_d;
  sel_cause_e           w_cause;
  logic [c_bus_w-1:0]   w_slice;
  logic [3:0]           w_slice_mode;

  next_src_finder #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_finder (
    .sel    (r_sel),
    .src_en (src_en),
    .nxt    (w_nxt),
    .none   (w_none)
  );

  // A load naming a missing or disabled source is dropped so lower terms apply
  assign w_load_ok  = sel_load && (int'(sel_value) < NUM_SRC) && src_en[sel_value];
  assign w_auto_adv = auto_en && enable && tick && (r_dwell == c_dwell_last);

  // Resolve the single selection write for this cycle in priority order
  always_comb begin
    w_cause = SEL_HOLD;
    w_sel_d = r_sel;
    if (w_load_ok) begin
      w_cause = SEL_LOAD;
      w_sel_d = sel_value;
    end else if (next_pulse) begin
      w_cause = SEL_NEXT;
      w_sel_d = w_nxt;
    end else if (w_auto_adv) begin
      w_cause = SEL_AUTO;
      w_sel_d = w_nxt;
    end else if (!src_en[r_sel] && !w_none) begin
      w_cause = SEL_FIX;
      w_sel_d = w_nxt;
    end
  end

  assign w_sel_write = (w_cause != SEL_HOLD);

  // Selection register and dwell counter; any selection write restarts dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= '0;
      r_dwell <= '0;
    end else begin
      r_sel <= w_sel_d;
      if (w_sel_write || !auto_en) begin
        r_dwell <= '0;
      end else if (enable && tick) begin
        r_dwell <= r_dwell + c_dwell_w'(1);
      end
    end
  end

  // Pick the currently selected source's digits and mode code
  always_comb begin
    w_slice      = '0;
    w_slice_mode = MODE_BLANK;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (r_sel == SEL_W'(s)) begin
        w_slice      = src_digits[s*c_bus_w +: c_bus_w];
        w_slice_mode = src_mode[s*4 +: 4];
      end
    end
  end

  // Registered output; source data streams through with one cycle of latency
  always_ff @(posedge clk) begin
    if (rst || !enable || w_none) begin
      r_digits <= '0;
      r_mode   <= MODE_BLANK;
      r_blank  <= 1'b1;
    end else begin
      r_digits <= w_slice;
      r_mode   <= w_slice_mode;
      r_blank  <= 1'b0;
    end
  end

  assign digits    = r_digits;
  assign mode_code = r_mode;
  assign sel       = r_sel;
  assign blank     = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_display_source_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_source_mux
// Description : Self-checking bench for display_source_mux and a stand-alone
//               check of next_src_finder, using a behavioural model of the
//               selection rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_source_mux;
  import display_pkg::*;

  localparam int NS = 4;
  localparam int ND = 4;
  localparam int DW = 4;
  localparam int DT = 3;
  localparam int BW = ND * DW;

  logic               clk;
  logic               rst;
  logic               enable;
  logic [NS*BW-1:0]   src_digits;
  logic [NS*4-1:0]    src_mode;
  logic [NS-1:0]      src_en;
  logic               next_pulse;
  logic               sel_load;
  logic [1:0]         sel_value;
  logic               auto_en;
  logic               tick;
  logic [BW-1:0]      digits;
  logic [3:0]         mode_code;
  logic [1:0]         sel;
  logic               blank;

  // stand-alone finder instances (power-of-two and non-power-of-two sizes)
  logic [1:0] f4_sel;
  logic [3:0] f4_en;
  logic [1:0] f4_nxt;
  logic       f4_none;
  logic [2:0] f5_sel;
  logic [4:0] f5_en;
  logic [2:0] f5_nxt;
  logic       f5_none;

  int checks;
  int errors;

  // behavioural model state
  int             m_sel;
  int             m_dwell;
  logic [BW-1:0]  m_digits;
  logic [3:0]     m_mode;
  logic           m_blank;

  display_source_mux #(
    .NUM_SRC     (NS),
    .NUM_DIGITS  (ND),
    .DIGIT_W     (DW),
    .DWELL_TICKS (DT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .src_digits (src_digits),
    .src_mode   (src_mode),
    .src_en     (src_en),
    .next_pulse (next_pulse),
    .sel_load   (sel_load),
    .sel_value  (sel_value),
    .auto_en    (auto_en),
    .tick       (tick),
    .digits     (digits),
    .mode_code  (mode_code),
    .sel        (sel),
    .blank      (blank)
  );

  next_src_finder #(.NUM_SRC(4)) u_f4 (
    .sel (f4_sel), .src_en (f4_en), .nxt (f4_nxt), .none (f4_none)
  );

  next_src_finder #(.NUM_SRC(5)) u_f5 (
    .sel (f5_sel), .src_en (f5_en), .nxt (f5_nxt), .none (f5_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // first enabled index strictly after s, cyclic; s itself if none other
  function automatic int model_next(int s, int en, int n);
    for (int k = 1; k < n; k++) begin
      if (en[(s + k) % n]) return (s + k) % n;
    end
    return s;
  endfunction

  // advance model and DUT by one clock using the current inputs
  task automatic clk_step();
    logic [BW-1:0] nd;
    logic [3:0]    nm;
    logic          nb;
    int            ns;
    int            ndw;
    bit            wr;
    int            en;
    en = int'(src_en);
    if (rst || !enable || en == 0) begin
      nd = '0; nm = 4'h0; nb = 1'b1;
    end else begin
      nd = src_digits[m_sel*BW +: BW];
      nm = src_mode[m_sel*4 +: 4];
      nb = 1'b0;
    end
    ns  = m_sel;
    ndw = m_dwell;
    if (rst) begin
      ns = 0; ndw = 0;
    end else begin
      wr = 1'b1;
      if (sel_load && int'(sel_value) < NS && en[int'(sel_value)])
        ns = int'(sel_value);
      else if (next_pulse)
        ns = model_next(m_sel, en, NS);
      else if (auto_en && enable && tick && m_dwell == DT - 1)
        ns = model_next(m_sel, en, NS);
      else if (!en[m_sel] && en != 0)
        ns = model_next(m_sel, en, NS);
      else
        wr = 1'b0;
      if (wr || !auto_en) ndw = 0;
      else if (enable && tick) ndw = m_dwell + 1;
    end
    @(posedge clk);
    #1;
    m_sel = ns; m_dwell = ndw; m_digits = nd; m_mode = nm; m_blank = nb;
  endtask

  // nine idle cycles followed by one tick cycle
  task automatic tick_period();
    repeat (9) clk_step();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_load = 1'b1; sel_value = 2'd2; next_pulse = 1'b1;
    enable = 1'b1; src_en = 4'hf; tick = 1'b1; auto_en = 1'b1;
    clk_step();
    clk_step();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (digits !== '0) begin errors++; $display("FAIL reset_digits got=%h exp=0", digits); end
    checks++; if (mode_code !== 4'h0) begin errors++; $display("FAIL reset_mode got=%h exp=0", mode_code); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", blank); end
    rst = 1'b0; sel_load = 1'b0; next_pulse = 1'b0; tick = 1'b0; auto_en = 1'b0;
  endtask

  task automatic test_basic();
    src_digits = {$urandom, $urandom};
    src_digits[15:0] = 16'h1234;
    src_mode = {4'h1, 4'h2, MODE_SS, MODE_HHMM};
    enable = 1'b1; src_en = 4'hf;
    clk_step(); clk_step();
    checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL basic_digits got=%h exp=1234", digits); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL basic_blank got=%b exp=0", blank); end
    checks++; if (mode_code !== MODE_HHMM) begin errors++; $display("FAIL basic_mode got=%h exp=%h", mode_code, MODE_HHMM); end
    src_digits[15:0] = 16'h5678;
    clk_step();
    checks++; if (digits !== 16'h5678) begin errors++; $display("FAIL basic_stream got=%h exp=5678", digits); end
  endtask

  task automatic test_skip();
    logic [BW-1:0] exp1;
    src_en = 4'b1011;
    sel_load = 1'b1; sel_value = 2'd1;
    clk_step();
    sel_load = 1'b0;
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL skip_load got=%0d exp=1", sel); end
    exp1 = src_digits[BW +: BW];
    clk_step();
    checks++; if (digits !== exp1) begin errors++; $display("FAIL skip_show1 got=%h exp=%h", digits, exp1); end
    next_pulse = 1'b1; clk_step(); next_pulse = 1'b0;
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL skip_next got=%0d exp=3", sel); end
    next_pulse = 1'b1; clk_step(); next_pulse = 1'b0;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL skip_wrap got=%0d exp=0", sel); end
  endtask

  task automatic test_load_priority();
    // load of a disabled source is dropped; the pulse advances instead
    sel_load = 1'b1; sel_value = 2'd2; next_pulse = 1'b1;
    clk_step();
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL load_disabled got=%0d exp=1", sel); end
    // valid load beats a simultaneous pulse
    sel_value = 2'd3;
    clk_step();
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL load_wins got=%0d exp=3", sel); end
    sel_load = 1'b0; next_pulse = 1'b0;
  endtask

  task automatic test_auto();
    src_en = 4'hf; auto_en = 1'b0; enable = 1'b1;
    sel_load = 1'b1; sel_value = 2'd0; clk_step(); sel_load = 1'b0;
    auto_en = 1'b1;
    tick_period(); tick_period();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL auto_hold got=%0d exp=0", sel); end
    tick_period();
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL auto_adv got=%0d exp=1", sel); end
    tick_period(); tick_period();
    next_pulse = 1'b1; clk_step(); next_pulse = 1'b0;
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL auto_pulse got=%0d exp=2", sel); end
    tick_period(); tick_period();
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL auto_dwell_reset got=%0d exp=2", sel); end
    tick_period();
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL auto_adv2 got=%0d exp=3", sel); end
    auto_en = 1'b0;
  endtask

  task automatic test_src_disable();
    logic [BW-1:0] exp2;
    logic [BW-1:0] exp3;
    src_en = 4'hf;
    sel_load = 1'b1; sel_value = 2'd2; clk_step(); sel_load = 1'b0;
    clk_step();
    exp2 = src_digits[2*BW +: BW];
    exp3 = src_digits[3*BW +: BW];
    src_en = 4'b1011;
    clk_step();
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL dis_fix got=%0d exp=3", sel); end
    checks++; if (digits !== exp2) begin errors++; $display("FAIL dis_stale got=%h exp=%h", digits, exp2); end
    clk_step();
    checks++; if (digits !== exp3) begin errors++; $display("FAIL dis_new got=%h exp=%h", digits, exp3); end
    src_en = 4'h0;
    clk_step();
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL none_blank got=%b exp=1", blank); end
    checks++; if (digits !== '0) begin errors++; $display("FAIL none_digits got=%h exp=0", digits); end
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL none_sel got=%0d exp=3", sel); end
    src_en = 4'hf;
  endtask

  task automatic test_enable_off();
    src_en = 4'hf; enable = 1'b1; auto_en = 1'b0;
    sel_load = 1'b1; sel_value = 2'd0; clk_step(); sel_load = 1'b0;
    auto_en = 1'b1;
    tick_period(); tick_period();
    enable = 1'b0;
    clk_step();
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL en_off_blank got=%b exp=1", blank); end
    tick_period(); tick_period();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL en_off_pause got=%0d exp=0", sel); end
    enable = 1'b1;
    tick_period();
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL en_dwell_held got=%0d exp=1", sel); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL en_on_blank got=%b exp=0", blank); end
    enable = 1'b0;
    next_pulse = 1'b1; clk_step(); next_pulse = 1'b0;
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL en_off_pulse got=%0d exp=2", sel); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    src_en = 4'hf; enable = 1'b1; auto_en = 1'b1;
    tick_period(); tick_period();
    rst = 1'b1; sel_load = 1'b1; sel_value = 2'd3; tick = 1'b1; next_pulse = 1'b1;
    clk_step();
    rst = 1'b0; sel_load = 1'b0; tick = 1'b0; next_pulse = 1'b0;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rstmid_sel got=%0d exp=0", sel); end
    checks++; if (blank !== 1'b1 || digits !== '0 || mode_code !== 4'h0)
      begin errors++; $display("FAIL rstmid_out got=%b/%h/%h exp=1/0/0", blank, digits, mode_code); end
    tick_period(); tick_period();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rstmid_dwell got=%0d exp=0", sel); end
    tick_period();
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL rstmid_adv got=%0d exp=1", sel); end
    auto_en = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      sel_load   = ($urandom_range(0, 9) == 0);
      sel_value  = 2'($urandom_range(0, 3));
      next_pulse = ($urandom_range(0, 11) == 0);
      tick       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) src_en = 4'($urandom_range(0, 15));
      src_digits[$urandom_range(0, NS*BW-1)] = 1'($urandom);
      if ($urandom_range(0, 15) == 0) src_mode = 16'($urandom);
      clk_step();
      checks++; if (sel !== 2'(m_sel)) begin errors++; $display("FAIL rnd_sel c=%0d got=%0d exp=%0d", c, sel, m_sel); end
      checks++; if (digits !== m_digits) begin errors++; $display("FAIL rnd_digits c=%0d got=%h exp=%h", c, digits, m_digits); end
      checks++; if (mode_code !== m_mode) begin errors++; $display("FAIL rnd_mode c=%0d got=%h exp=%h", c, mode_code, m_mode); end
      checks++; if (blank !== m_blank) begin errors++; $display("FAIL rnd_blank c=%0d got=%b exp=%b", c, blank, m_blank); end
    end
    rst = 1'b0; sel_load = 1'b0; next_pulse = 1'b0; tick = 1'b0;
  endtask

  task automatic test_finder();
    for (int s = 0; s < 4; s++) begin
      for (int e = 0; e < 16; e++) begin
        f4_sel = 2'(s); f4_en = 4'(e);
        #1;
        checks++; if (f4_nxt !== 2'(model_next(s, e, 4)) || f4_none !== (e == 0))
          begin errors++; $display("FAIL finder4 s=%0d en=%h got=%0d/%b exp=%0d/%b", s, e, f4_nxt, f4_none, model_next(s, e, 4), e == 0); end
      end
    end
    for (int s = 0; s < 5; s++) begin
      for (int e = 0; e < 32; e++) begin
        f5_sel = 3'(s); f5_en = 5'(e);
        #1;
        checks++; if (f5_nxt !== 3'(model_next(s, e, 5)) || f5_none !== (e == 0))
          begin errors++; $display("FAIL finder5 s=%0d en=%h got=%0d/%b exp=%0d/%b", s, e, f5_nxt, f5_none, model_next(s, e, 5), e == 0); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_sel = 0; m_dwell = 0; m_digits = '0; m_mode = 4'h0; m_blank = 1'b1;
    rst = 1'b1; enable = 1'b0; src_digits = '0; src_mode = '0; src_en = '0;
    next_pulse = 1'b0; sel_load = 1'b0; sel_value = '0; auto_en = 1'b0; tick = 1'b0;
    f4_sel = '0; f4_en = '0; f5_sel = '0; f5_en = '0;
    test_finder();
    test_reset();
    test_basic();
    test_skip();
    test_load_priority();
    test_auto();
    test_src_disable();
    test_enable_off();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
